bram_stream_loader: RTL and testbench

Host-side loader that sits directly upstream of the GAT accelerator top level and feeds its five input BRAM write ports (H col_idx, H value, H node_info, Weight, a). It accepts a single valid/ready word stream of framed packets and demultiplexes each packet onto one target BRAM with auto-incrementing addresses. It raises the per-target `load_done` flags that gate SPMM, the scheduler and DMVM start.

---
 rtl/params_pkg.sv | 29 ++
 rtl/bram_stream_loader.sv | 154 +++++++++++++++
 tb/tb_bram_stream_loader.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/params_pkg.sv
// Shared constants and types for the BRAM stream loader.
package params_pkg;

    // BRAM target indices; also the bit positions in bram_ena / load_done.
    localparam int unsigned TGT_COL_IDX   = 0;
    localparam int unsigned TGT_VALUE     = 1;
    localparam int unsigned TGT_NODE_INFO = 2;
    localparam int unsigned TGT_WEIGHT    = 3;
    localparam int unsigned TGT_A         = 4;
    localparam int unsigned NUM_TGT       = 5;

    // Header word layout: target in the top three bits, length in the low LEN_W bits.
    localparam int unsigned HDR_TGT_MSB = 31;
    localparam int unsigned HDR_TGT_LSB = 29;
    localparam int unsigned HDR_TGT_W   = HDR_TGT_MSB - HDR_TGT_LSB + 1;
    localparam int unsigned HDR_LEN_LSB = 0;

    typedef enum logic [1:0] {
        HDR,
        LOAD,
        DRAIN
    } loader_state_t;

    // One-hot decode of a target index; out-of-range indices give all zeros.
    function automatic logic [NUM_TGT-1:0] tgt_onehot(input logic [HDR_TGT_W-1:0] tgt);
        return NUM_TGT'(1) << tgt;
    endfunction

endpackage

// File: rtl/bram_stream_loader.sv
// Demultiplexes a framed valid/ready word stream onto five BRAM write ports
// with auto-incrementing addresses and sticky per-target done flags.
module bram_stream_loader
    import params_pkg::*;
#(
    parameter int unsigned IN_W   = 32,
    parameter int unsigned DOUT_W = 32,
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned LEN_W  = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [IN_W-1:0]    s_data,
    input  logic               s_valid,
    input  logic               s_last,
    output logic               s_ready,
    input  logic               clear_i,
    output logic [DOUT_W-1:0]  bram_din,
    output logic [ADDR_W-1:0]  bram_addra,
    output logic [NUM_TGT-1:0] bram_ena,
    output logic [NUM_TGT-1:0] load_done,
    output logic               all_done,
    output logic [1:0]         err_o
);

    loader_state_t          state_q, state_d;
    logic [HDR_TGT_W-1:0]   tgt_q, tgt_d;
    logic [LEN_W-1:0]       rem_q, rem_d;
    logic [ADDR_W-1:0]      cnt_q, cnt_d;
    logic                   ready_q;
    logic [NUM_TGT-1:0]     ena_q, ena_d;
    logic [DOUT_W-1:0]      din_q, din_d;
    logic [ADDR_W-1:0]      addr_q, addr_d;
    logic [NUM_TGT-1:0]     done_q, done_d;
    logic [NUM_TGT-1:0]     pend_q, pend_d;
    logic [1:0]             err_q, err_d;

    logic                   accept;
    logic [HDR_TGT_W-1:0]   hdr_tgt;
    logic [LEN_W-1:0]       hdr_len;
    logic                   hdr_tgt_ok;
    logic [NUM_TGT-1:0]     done_clr, done_set;
    logic [1:0]             err_set;

    assign accept     = s_valid && ready_q;
    assign hdr_tgt    = s_data[HDR_TGT_MSB:HDR_TGT_LSB];
    assign hdr_len    = s_data[HDR_LEN_LSB +: LEN_W];
    assign hdr_tgt_ok = hdr_tgt <= HDR_TGT_W'(TGT_A);

    // Packet parser: next state, counters, write stage and flag set/clear terms.
    always_comb begin
        state_d  = state_q;
        tgt_d    = tgt_q;
        rem_d    = rem_q;
        cnt_d    = cnt_q;
        ena_d    = '0;
        din_d    = din_q;
        addr_d   = addr_q;
        pend_d   = '0;
        done_clr = '0;
        done_set = '0;
        err_set  = '0;
        case (state_q)
            HDR: begin
                if (accept) begin
                    if (hdr_tgt_ok) begin
                        tgt_d    = hdr_tgt;
                        rem_d    = hdr_len;
                        cnt_d    = '0;
                        done_clr = tgt_onehot(hdr_tgt);
                        if (hdr_len == '0) begin
                            done_set = tgt_onehot(hdr_tgt);
                        end else begin
                            state_d = LOAD;
                        end
                    end else begin
                        err_set[0] = 1'b1;
                        if (!s_last) begin
                            state_d = DRAIN;
                        end
                    end
                end
            end
            LOAD: begin
                if (accept) begin
                    ena_d  = tgt_onehot(tgt_q);
                    din_d  = DOUT_W'(s_data);
                    addr_d = cnt_q;
                    cnt_d  = cnt_q + 1'b1;
                    rem_d  = rem_q - 1'b1;
                    // Length wins over s_last: a missing last on the final word is tolerated.
                    if (rem_q == LEN_W'(1)) begin
                        pend_d  = tgt_onehot(tgt_q);
                        state_d = HDR;
                    end else if (s_last) begin
                        err_set[1] = 1'b1;
                        state_d    = HDR;
                    end
                end
            end
            DRAIN: begin
                if (accept && s_last) begin
                    state_d = HDR;
                end
            end
            default: state_d = HDR;
        endcase
    end

    // Sticky flags: clears (header, clear_i) apply first, sets win on collision.
    // Completion is delayed one cycle via pend_q so the last write lands first.
    always_comb begin
        done_d = (done_q & ~done_clr & ~{NUM_TGT{clear_i}}) | done_set | pend_q;
        err_d  = (err_q & ~{2{clear_i}}) | err_set;
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= HDR;
            tgt_q   <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
            ready_q <= 1'b0;
            ena_q   <= '0;
            din_q   <= '0;
            addr_q  <= '0;
            done_q  <= '0;
            pend_q  <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            tgt_q   <= tgt_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            ready_q <= 1'b1;
            ena_q   <= ena_d;
            din_q   <= din_d;
            addr_q  <= addr_d;
            done_q  <= done_d;
            pend_q  <= pend_d;
            err_q   <= err_d;
        end
    end

    assign s_ready    = ready_q;
    assign bram_ena   = ena_q;
    assign bram_din   = din_q;
    assign bram_addra = addr_q;
    assign load_done  = done_q;
    assign all_done   = &done_q;
    assign err_o      = err_q;

endmodule

// File: tb/tb_bram_stream_loader.sv
// Self-checking bench: packet-level reference model, per-cycle compare,
// directed scenarios with literal expectations and randomized packets.
module tb_bram_stream_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] s_data = '0;
    logic        s_valid = 1'b0;
    logic        s_last = 1'b0;
    logic        clear_i = 1'b0;
    logic        s_ready;
    logic [31:0] bram_din;
    logic [15:0] bram_addra;
    logic [4:0]  bram_ena;
    logic [4:0]  load_done;
    logic        all_done;
    logic [1:0]  err_o;

    always #5 clk = ~clk;

    bram_stream_loader dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .s_data     (s_data),
        .s_valid    (s_valid),
        .s_last     (s_last),
        .s_ready    (s_ready),
        .clear_i    (clear_i),
        .bram_din   (bram_din),
        .bram_addra (bram_addra),
        .bram_ena   (bram_ena),
        .load_done  (load_done),
        .all_done   (all_done),
        .err_o      (err_o)
    );

    int n_chk = 0;
    int n_bad = 0;

    // Expected outputs after the most recent clock edge.
    logic [4:0]  exp_ena = '0;
    logic [31:0] exp_din = '0;
    logic [15:0] exp_addr = '0;
    logic [4:0]  exp_done = '0;
    logic [4:0]  pend = '0;
    logic [1:0]  exp_err = '0;
    logic        exp_ready = 1'b0;

    // Packet position: 0 expecting header, 1 inside a packet, 2 discarding.
    int m_mode = 0;
    int m_tgt = 0;
    int m_n = 0;
    int m_k = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h want %h at %0t", name, got, want, $time);
        end
    endtask

    task automatic compare_all();
        chk("s_ready", 32'(s_ready), 32'(exp_ready));
        chk("bram_ena", 32'(bram_ena), 32'(exp_ena));
        if (exp_ena != 5'b0) begin
            chk("bram_din", bram_din, exp_din);
            chk("bram_addra", 32'(bram_addra), 32'(exp_addr));
        end
        chk("load_done", 32'(load_done), 32'(exp_done));
        chk("all_done", 32'(all_done), 32'(&exp_done));
        chk("err_o", 32'(err_o), 32'(exp_err));
    endtask

    task automatic model_reset();
        exp_ena   = '0;
        exp_din   = '0;
        exp_addr  = '0;
        exp_done  = '0;
        pend      = '0;
        exp_err   = '0;
        exp_ready = 1'b0;
        m_mode    = 0;
    endtask

    // Drive one cycle of inputs, advance the model by one cycle, compare after the edge.
    task automatic step(input logic v, input logic [31:0] d, input logic l, input logic clr);
        logic [4:0]  w_ena;
        logic [31:0] w_din;
        logic [15:0] w_addr;
        logic [4:0]  hclr;
        logic [4:0]  hset;
        logic [4:0]  cset;
        logic [1:0]  eset;
        int          t;
        int          n;
        w_ena = '0; w_din = '0; w_addr = '0;
        hclr = '0; hset = '0; cset = '0; eset = '0;
        s_valid = v; s_data = d; s_last = l; clear_i = clr;
        if (v && exp_ready) begin
            if (m_mode == 0) begin
                t = int'(d[31:29]);
                n = int'(d[15:0]);
                if (t < 5) begin
                    hclr = 5'(1 << t);
                    if (n == 0) begin
                        hset = 5'(1 << t);
                    end else begin
                        m_mode = 1; m_tgt = t; m_n = n; m_k = 0;
                    end
                end else begin
                    eset[0] = 1'b1;
                    if (!l) m_mode = 2;
                end
            end else if (m_mode == 1) begin
                w_ena  = 5'(1 << m_tgt);
                w_din  = d;
                w_addr = 16'(m_k);
                m_k++;
                if (m_k == m_n) begin
                    cset = 5'(1 << m_tgt);
                    m_mode = 0;
                end else if (l) begin
                    eset[1] = 1'b1;
                    m_mode = 0;
                end
            end else begin
                if (l) m_mode = 0;
            end
        end
        @(posedge clk);
        #1;
        exp_ena = w_ena;
        if (w_ena != 5'b0) begin
            exp_din  = w_din;
            exp_addr = w_addr;
        end
        exp_done  = (exp_done & ~hclr & ~{5{clr}}) | hset | pend;
        pend      = cset;
        exp_err   = (exp_err & ~{2{clr}}) | eset;
        exp_ready = rst_n;
        compare_all();
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) step(1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic send_word(input logic [31:0] d, input logic l);
        if ($urandom_range(0, 3) == 0) step(1'b0, $urandom, 1'b0, $urandom_range(0, 19) == 0);
        step(1'b1, d, l, 1'b0);
    endtask

    task automatic rand_packet();
        int          t;
        int          n;
        int          k;
        int          trunc;
        logic        missing;
        logic [31:0] hdr;
        t = ($urandom_range(0, 3) == 0) ? int'($urandom_range(5, 7)) : int'($urandom_range(0, 4));
        n = int'($urandom_range(0, 6));
        hdr = {3'(t), 13'($urandom), 16'(n)};
        if (t > 4) begin
            k = int'($urandom_range(0, 3));
            send_word(hdr, k == 0);
            for (int i = 1; i <= k; i++) send_word($urandom, i == k);
        end else if (n == 0) begin
            send_word(hdr, 1'($urandom_range(0, 1)));
        end else begin
            send_word(hdr, 1'b0);
            trunc = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, n)) : n;
            missing = ($urandom_range(0, 7) == 0);
            for (int i = 1; i <= trunc; i++) begin
                send_word($urandom, (i == trunc) && !((i == n) && missing));
            end
        end
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        compare_all();
        chk("reset_ena", 32'(bram_ena), 32'h0);
        chk("reset_ready", 32'(s_ready), 32'h0);
        rst_n = 1'b1;
        idle(1);
        chk("ready_after_reset", 32'(s_ready), 32'h1);

        // tgt=3, N=4
        step(1'b1, 32'h6000_0004, 1'b0, 1'b0);
        step(1'b1, 32'hA, 1'b0, 1'b0);
        chk("t1_ena0", 32'(bram_ena), 32'h08);
        chk("t1_addr0", 32'(bram_addra), 32'h0);
        chk("t1_din0", bram_din, 32'hA);
        step(1'b1, 32'hB, 1'b0, 1'b0);
        step(1'b1, 32'hC, 1'b0, 1'b0);
        step(1'b1, 32'hD, 1'b1, 1'b0);
        chk("t1_addr3", 32'(bram_addra), 32'h3);
        chk("t1_done_early", 32'(load_done), 32'h0);
        idle(1);
        chk("t1_done", 32'(load_done), 32'h08);

        // All five targets back to back, N=2
        for (int t = 0; t < 5; t++) begin
            step(1'b1, {3'(t), 29'h2}, 1'b0, 1'b0);
            step(1'b1, 32'h100 + 32'(t), 1'b0, 1'b0);
            step(1'b1, 32'h200 + 32'(t), 1'b1, 1'b0);
        end
        chk("b2b_all_early", 32'(all_done), 32'h0);
        idle(1);
        chk("b2b_all_done", 32'(all_done), 32'h1);

        // Invalid target drained, then a normal load
        step(1'b0, 32'h0, 1'b0, 1'b1);
        step(1'b1, 32'hC000_0003, 1'b0, 1'b0);
        step(1'b1, 32'h1, 1'b0, 1'b0);
        chk("inv_no_write", 32'(bram_ena), 32'h0);
        step(1'b1, 32'h2, 1'b0, 1'b0);
        step(1'b1, 32'h3, 1'b1, 1'b0);
        chk("inv_err", 32'(err_o), 32'h1);
        step(1'b1, 32'h0000_0001, 1'b0, 1'b0);
        step(1'b1, 32'h55, 1'b1, 1'b0);
        chk("inv_next_ena", 32'(bram_ena), 32'h01);
        idle(1);
        chk("inv_next_done", 32'(load_done[0]), 32'h1);

        // Truncated packet
        step(1'b1, 32'h2000_0005, 1'b0, 1'b0);
        step(1'b1, 32'h11, 1'b0, 1'b0);
        step(1'b1, 32'h22, 1'b1, 1'b0);
        chk("trunc_addr1", 32'(bram_addra), 32'h1);
        idle(2);
        chk("trunc_err", 32'(err_o[1]), 32'h1);
        chk("trunc_done", 32'(load_done[1]), 32'h0);

        // clear_i then N=0 reload
        step(1'b1, 32'h8000_0001, 1'b0, 1'b0);
        step(1'b1, 32'h77, 1'b1, 1'b0);
        idle(1);
        step(1'b0, 32'h0, 1'b0, 1'b1);
        chk("clear_done", 32'(load_done), 32'h0);
        chk("clear_err", 32'(err_o), 32'h0);
        step(1'b1, 32'h8000_0000, 1'b1, 1'b0);
        chk("n0_done", 32'(load_done), 32'h10);

        // Asynchronous reset mid-load
        step(1'b1, 32'h4000_0008, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 32'h300 + 32'(i), 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("arst_ena", 32'(bram_ena), 32'h0);
        chk("arst_done", 32'(load_done), 32'h0);
        chk("arst_ready", 32'(s_ready), 32'h0);
        @(posedge clk);
        #1;
        idle(1);
        rst_n = 1'b1;
        idle(1);
        step(1'b1, 32'h4000_0001, 1'b0, 1'b0);
        step(1'b1, 32'h99, 1'b1, 1'b0);
        chk("arst_hdr_ena", 32'(bram_ena), 32'h04);
        chk("arst_hdr_addr", 32'(bram_addra), 32'h0);

        // Randomized packets
        for (int p = 0; p < 400; p++) rand_packet();
        idle(3);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
